// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: RV32I instruction-fetch stage.
// Owns the PC and keeps at most one instruction-memory request outstanding.
// It also fills the IF/ID register. A one-entry skid buffer catches a response
// that lands while decode is stalled. An EX redirect (flush) overrides every
// other transition. A request killed by a flush is drained in DROP.
`ifndef XLEN
`define XLEN 32
`endif

module rv_fetch_stage #(
  parameter logic [`XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [`XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  output logic             o_if_imem_req,
  output logic [`XLEN-1:0] o_if_imem_addr,
  input  logic             i_if_imem_gnt,
  input  logic             i_if_imem_rvalid,
  input  logic [`XLEN-1:0] i_if_imem_rdata,
  input  logic             i_if_stall,
  input  logic             i_if_flush,
  input  logic [`XLEN-1:0] i_if_target,
  output logic [`XLEN-1:0] o_if_pc_id,
  output logic [`XLEN-1:0] o_if_instr_id,
  output logic             o_if_valid_id
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  // Clear the two low address bits; fetches are always word aligned.
  function automatic logic [`XLEN-1:0] word_align(input logic [`XLEN-1:0] addr);
    return addr & {{(`XLEN-2){1'b1}}, 2'b00};
  endfunction

  state_e           state_q, state_d;
  logic [`XLEN-1:0] pc_q, pc_d;
  logic [`XLEN-1:0] req_pc_q, req_pc_d;
  logic [`XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [`XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [`XLEN-1:0] id_pc_q, id_pc_d;
  logic [`XLEN-1:0] id_instr_q, id_instr_d;
  logic             id_valid_q, id_valid_d;
  logic [`XLEN-1:0] req_pc_inc_s;

  // Sequential PC after the outstanding fetch; the add wraps modulo 2^32.
  assign req_pc_inc_s = req_pc_q + 32'd4;

  // The request is a pure decode of the state register and is masked during reset.
  assign o_if_imem_req  = (state_q == S_REQ) && i_rstn;
  assign o_if_imem_addr = pc_q;
  assign o_if_pc_id     = id_pc_q;
  assign o_if_instr_id  = id_instr_q;
  assign o_if_valid_id  = id_valid_q;

  // Next-state logic: a flush wins over stall and over every normal transition.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    id_pc_d      = id_pc_q;
    id_instr_d   = id_instr_q;
    id_valid_d   = id_valid_q;

    if (i_if_flush) begin
      pc_d         = word_align(i_if_target);
      skid_pc_d    = {`XLEN{1'b0}};
      skid_instr_d = NOP_INSTR;
      id_pc_d      = {`XLEN{1'b0}};
      id_instr_d   = NOP_INSTR;
      id_valid_d   = 1'b0;
      case (state_q)
        // A request granted together with the flush went to the stale PC.
        S_REQ: begin
          if (i_if_imem_gnt) begin
            state_d = S_DROP;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (i_if_imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end
        S_HOLD: state_d = S_REQ;
        S_DROP: begin
          if (i_if_imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (i_if_imem_gnt) begin
            req_pc_d = pc_q;
            state_d  = S_WAIT;
          end else begin
            state_d  = S_REQ;
          end
        end
        S_WAIT: begin
          if (i_if_imem_rvalid) begin
            pc_d = req_pc_inc_s;
            if (i_if_stall) begin
              // Decode is frozen, so park the word in the skid buffer.
              skid_pc_d    = req_pc_q;
              skid_instr_d = i_if_imem_rdata;
              state_d      = S_HOLD;
            end else begin
              id_pc_d    = req_pc_q;
              id_instr_d = i_if_imem_rdata;
              id_valid_d = 1'b1;
              state_d    = S_REQ;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!i_if_stall) begin
            id_pc_d    = skid_pc_q;
            id_instr_d = skid_instr_q;
            id_valid_d = 1'b1;
            state_d    = S_REQ;
          end else begin
            state_d    = S_HOLD;
          end
        end
        S_DROP: begin
          if (i_if_imem_rvalid) begin
            state_d = S_REQ;
          end else begin
            state_d = S_DROP;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State and datapath registers, with a synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q      <= S_REQ;
      pc_q         <= word_align(RESET_PC);
      req_pc_q     <= {`XLEN{1'b0}};
      skid_pc_q    <= {`XLEN{1'b0}};
      skid_instr_q <= NOP_INSTR;
      id_pc_q      <= {`XLEN{1'b0}};
      id_instr_q   <= NOP_INSTR;
      id_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      id_pc_q      <= id_pc_d;
      id_instr_q   <= id_instr_d;
      id_valid_q   <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Directed bench for rv_fetch_stage.
// A negedge memory model returns rdata = addr ^ 32'hA5A5_0000 with
// programmable grant and response delays, and logs every handshake address.
// Scenario tasks drive stall/flush/reset just after the falling edge and
// check the outputs against hand-computed values.
module tb_rv_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req;
  logic [31:0] addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] target = 32'h0;
  logic [31:0] pc_id;
  logic [31:0] instr_id;
  logic        valid_id;

  int checks = 0;
  int errors = 0;
  int proto_err = 0;
  int gnt_dly = 0;
  int rv_dly = 0;
  logic [31:0] hs_q[$];

  rv_fetch_stage dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .o_if_imem_req    (req),
    .o_if_imem_addr   (addr),
    .i_if_imem_gnt    (mem_gnt),
    .i_if_imem_rvalid (mem_rvalid),
    .i_if_imem_rdata  (mem_rdata),
    .i_if_stall       (stall),
    .i_if_flush       (flush),
    .i_if_target      (target),
    .o_if_pc_id       (pc_id),
    .o_if_instr_id    (instr_id),
    .o_if_valid_id    (valid_id)
  );

  initial forever #5 clk = ~clk;

  // Memory model: one response per handshake; it also checks request-protocol rules.
  initial begin
    logic        hs_flag, pending, req_prev;
    logic [31:0] hs_addr, pend_addr, addr_prev;
    int          gnt_cnt, rv_cnt;
    hs_flag = 1'b0; pending = 1'b0; req_prev = 1'b0;
    hs_addr = 32'h0; pend_addr = 32'h0; addr_prev = 32'h0;
    gnt_cnt = 0; rv_cnt = 0;
    forever begin
      @(negedge clk);
      // An ungranted request must stay up with a stable address unless flushed.
      if (req_prev && !mem_gnt && !flush && rstn && (!req || addr != addr_prev)) proto_err++;
      req_prev  = req;
      addr_prev = addr;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (!rstn) begin
        hs_flag = 1'b0; pending = 1'b0; gnt_cnt = 0;
      end else begin
        if (hs_flag) begin
          hs_flag = 1'b0; pending = 1'b1; pend_addr = hs_addr; rv_cnt = rv_dly;
          hs_q.push_back(hs_addr);
        end
        if (req && pending) proto_err++;
        if (pending) begin
          if (rv_cnt == 0) begin
            mem_rvalid = 1'b1; mem_rdata = pend_addr ^ KEY; pending = 1'b0;
          end else begin
            rv_cnt--;
          end
        end else if (req) begin
          if (gnt_cnt >= gnt_dly) begin
            mem_gnt = 1'b1; hs_flag = 1'b1; hs_addr = addr; gnt_cnt = 0;
          end else begin
            gnt_cnt++;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; stall = 1'b0; flush = 1'b0; target = 32'h0;
    repeat (3) cyc();
    rstn = 1'b1;
    #1;
  endtask

  // Wait (bounded) until IF/ID holds a valid entry for exp_pc.
  task automatic wait_valid_pc(input logic [31:0] exp_pc, output bit ok, output int n);
    n = 0;
    while (!(valid_id && pc_id == exp_pc) && n < 60) begin
      cyc();
      n++;
    end
    ok = valid_id && (pc_id == exp_pc);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", req); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", valid_id); end
    checks++; if (instr_id !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", instr_id, NOP); end
    checks++; if (pc_id !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", pc_id); end
    rstn = 1'b1;
    #1;
    checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin
      errors++; $display("FAIL rst_release: req=%b addr=%h want req=1 addr=0", req, addr);
    end
  endtask

  task automatic test_sequential();
    int base, n;
    bit ok;
    logic [31:0] exp_pc;
    gnt_dly = 0; rv_dly = 0;
    do_reset();
    base = hs_q.size();
    cyc(); cyc();
    checks++;
    if (valid_id !== 1'b0 || instr_id !== NOP) begin
      errors++; $display("FAIL seq_pre_resp: valid=%b instr=%h want 0/%h", valid_id, instr_id, NOP);
    end
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      wait_valid_pc(exp_pc, ok, n);
      checks++;
      if (!ok || instr_id !== (exp_pc ^ KEY)) begin
        errors++; $display("FAIL seq_id: pc=%h instr=%h valid=%b want pc=%h instr=%h", pc_id, instr_id, valid_id, exp_pc, exp_pc ^ KEY);
      end
      if (i > 0) begin
        checks++;
        if (n !== 2) begin errors++; $display("FAIL seq_rate: %0d cycles per instr, want 2", n); end
      end
    end
    cyc(); cyc();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_q.size() <= base + i || hs_q[base + i] !== 32'(i * 4)) begin
        errors++; $display("FAIL seq_addr[%0d]: want %h", i, 32'(i * 4));
      end
    end
  endtask

  task automatic test_latency();
    int base, n;
    bit ok;
    logic [31:0] exp_pc;
    gnt_dly = 3; rv_dly = 2;
    do_reset();
    base = hs_q.size();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i * 4);
      wait_valid_pc(exp_pc, ok, n);
      checks++;
      if (!ok || instr_id !== (exp_pc ^ KEY)) begin
        errors++; $display("FAIL lat_id: pc=%h instr=%h valid=%b want pc=%h", pc_id, instr_id, valid_id, exp_pc);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (hs_q.size() <= base + i || hs_q[base + i] !== 32'(i * 4)) begin
        errors++; $display("FAIL lat_addr[%0d]: want %h", i, 32'(i * 4));
      end
    end
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL lat_protocol: %0d violations, want 0", proto_err); end
  endtask

  task automatic test_stall();
    int base, n;
    bit ok;
    gnt_dly = 0; rv_dly = 0;
    do_reset();
    base = hs_q.size();
    wait_valid_pc(32'h0, ok, n);
    wait_valid_pc(32'h4, ok, n);
    n = 0;
    while (!(mem_rvalid && mem_rdata == (32'h8 ^ KEY)) && n < 20) begin cyc(); n++; end
    checks++;
    if (!(mem_rvalid && mem_rdata == (32'h8 ^ KEY))) begin errors++; $display("FAIL stall_sync: no response for pc 8"); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (valid_id !== 1'b1 || pc_id !== 32'h4 || instr_id !== (32'h4 ^ KEY) || req !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h req=%b want 1/4/%h/0", i, valid_id, pc_id, instr_id, req, 32'h4 ^ KEY);
      end
    end
    stall = 1'b0;
    cyc();
    checks++;
    if (valid_id !== 1'b1 || pc_id !== 32'h8 || instr_id !== (32'h8 ^ KEY)) begin
      errors++; $display("FAIL stall_release: valid=%b pc=%h instr=%h want 1/8/%h", valid_id, pc_id, instr_id, 32'h8 ^ KEY);
    end
    wait_valid_pc(32'hC, ok, n);
    checks++;
    if (!ok || instr_id !== (32'hC ^ KEY)) begin errors++; $display("FAIL stall_next: pc=%h instr=%h want c", pc_id, instr_id); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hs_q.size() <= base + i || hs_q[base + i] !== 32'(i * 4)) begin
        errors++; $display("FAIL stall_addr[%0d]: want %h", i, 32'(i * 4));
      end
    end
  endtask

  task automatic test_flush_wait();
    int base, n;
    gnt_dly = 0; rv_dly = 2;
    do_reset();
    base = hs_q.size();
    n = 0;
    while (!(hs_q.size() > base && hs_q[hs_q.size() - 1] == 32'h10) && n < 80) begin cyc(); n++; end
    checks++;
    if (!(hs_q.size() > base && hs_q[hs_q.size() - 1] == 32'h10)) begin errors++; $display("FAIL flw_sync: no fetch of pc 16"); end
    flush = 1'b1; target = 32'h0000_0100;
    cyc();
    flush = 1'b0;
    checks++;
    if (valid_id !== 1'b0 || instr_id !== NOP || pc_id !== 32'h0 || req !== 1'b0) begin
      errors++; $display("FAIL flw_bubble: valid=%b instr=%h pc=%h req=%b want 0/%h/0/0", valid_id, instr_id, pc_id, req, NOP);
    end
    n = 0;
    while (!valid_id && n < 40) begin cyc(); n++; end
    checks++;
    if (valid_id !== 1'b1 || pc_id !== 32'h100 || instr_id !== (32'h100 ^ KEY)) begin
      errors++; $display("FAIL flw_first: valid=%b pc=%h instr=%h want 1/100/%h", valid_id, pc_id, instr_id, 32'h100 ^ KEY);
    end
    checks++;
    if (hs_q.size() <= base + 5 || hs_q[base + 5] !== 32'h100) begin errors++; $display("FAIL flw_addr: next fetch not 100"); end
  endtask

  task automatic test_flush_rvalid_stall();
    int base, n;
    bit ok;
    gnt_dly = 0; rv_dly = 0;
    do_reset();
    base = hs_q.size();
    wait_valid_pc(32'h0, ok, n);
    n = 0;
    while (!(mem_rvalid && mem_rdata == (32'h4 ^ KEY)) && n < 20) begin cyc(); n++; end
    checks++;
    if (!(mem_rvalid && mem_rdata == (32'h4 ^ KEY))) begin errors++; $display("FAIL frs_sync: no response for pc 4"); end
    stall = 1'b1; flush = 1'b1; target = 32'h0000_0203;
    cyc();
    checks++;
    if (valid_id !== 1'b0 || instr_id !== NOP || pc_id !== 32'h0) begin
      errors++; $display("FAIL frs_bubble: valid=%b instr=%h pc=%h want 0/%h/0", valid_id, instr_id, pc_id, NOP);
    end
    checks++;
    if (req !== 1'b1 || addr !== 32'h200) begin errors++; $display("FAIL frs_addr: req=%b addr=%h want 1/200", req, addr); end
    flush = 1'b0; stall = 1'b0;
    n = 0;
    while (!valid_id && n < 40) begin cyc(); n++; end
    checks++;
    if (valid_id !== 1'b1 || pc_id !== 32'h200 || instr_id !== (32'h200 ^ KEY)) begin
      errors++; $display("FAIL frs_first: valid=%b pc=%h instr=%h want 1/200/%h", valid_id, pc_id, instr_id, 32'h200 ^ KEY);
    end
  endtask

  task automatic test_wrap();
    int base, n;
    bit ok;
    gnt_dly = 0; rv_dly = 0;
    do_reset();
    base = hs_q.size();
    n = 0;
    while (hs_q.size() <= base && n < 20) begin cyc(); n++; end
    flush = 1'b1; target = 32'hFFFF_FFFC;
    cyc();
    flush = 1'b0;
    checks++;
    if (addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h want fffffffc", addr); end
    wait_valid_pc(32'hFFFF_FFFC, ok, n);
    checks++;
    if (!ok || instr_id !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_top: pc=%h instr=%h want fffffffc/5a5afffc", pc_id, instr_id); end
    wait_valid_pc(32'h0, ok, n);
    checks++;
    if (!ok || instr_id !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_zero: pc=%h instr=%h want 0/a5a50000", pc_id, instr_id); end
    checks++;
    if (hs_q.size() <= base + 2 || hs_q[base + 1] !== 32'hFFFF_FFFC || hs_q[base + 2] !== 32'h0) begin
      errors++; $display("FAIL wrap_seq: fetch order after fffffffc is not 0");
    end
  endtask

  task automatic test_reset_in_wait();
    int base, n;
    bit ok;
    gnt_dly = 0; rv_dly = 3;
    do_reset();
    base = hs_q.size();
    wait_valid_pc(32'h0, ok, n);
    n = 0;
    while (hs_q.size() <= base + 1 && n < 20) begin cyc(); n++; end
    rstn = 1'b0;
    cyc();
    checks++;
    if (req !== 1'b0 || valid_id !== 1'b0 || instr_id !== NOP || pc_id !== 32'h0) begin
      errors++; $display("FAIL rw_reset: req=%b valid=%b instr=%h pc=%h want 0/0/%h/0", req, valid_id, instr_id, pc_id, NOP);
    end
    cyc();
    rstn = 1'b1;
    #1;
    base = hs_q.size();
    checks++;
    if (req !== 1'b1 || addr !== 32'h0) begin errors++; $display("FAIL rw_restart: req=%b addr=%h want 1/0", req, addr); end
    wait_valid_pc(32'h0, ok, n);
    checks++;
    if (!ok || instr_id !== KEY) begin errors++; $display("FAIL rw_first: pc=%h instr=%h want 0/%h", pc_id, instr_id, KEY); end
    checks++;
    if (hs_q.size() <= base || hs_q[base] !== 32'h0) begin errors++; $display("FAIL rw_addr: first fetch after reset not 0"); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency();
    test_stall();
    test_flush_wait();
    test_flush_rvalid_stall();
    test_wrap();
    test_reset_in_wait();
    checks++;
    if (proto_err !== 0) begin errors++; $display("FAIL protocol: %0d request-rule violations, want 0", proto_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
